// File: rtl/updown_counter_param_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : updown_counter_param_pkg
//  Brief    : Shared constants and helpers for the parametrised up/down
//             modulo counter and its prescaler.
//  Revision : 1.0  initial release
// ============================================================================
package updown_counter_param_pkg;

    // Boundary behaviour selected by the SATURATE parameter
    localparam int   MODE_WRAP = 0;
    localparam int   MODE_SAT  = 1;

    // Encoding of the down input
    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;

    // Legal parameter ranges
    localparam int   MIN_WIDTH    = 1;
    localparam int   MAX_WIDTH    = 32;
    localparam int   MIN_PRESCALE = 1;
    localparam int   MAX_PRESCALE = 65535;

    // Width of the prescaler phase counter; never below one bit so that a
    // degenerate PRESCALE still yields a legal vector declaration.
    function automatic int prescale_cnt_width(input int prescale);
        return (prescale > 1) ? $clog2(prescale) : 1;
    endfunction

endpackage : updown_counter_param_pkg
`default_nettype wire

// File: rtl/updown_counter_param_prescaler_tick.sv
`default_nettype none
// ============================================================================
//  Module   : updown_counter_param_prescaler_tick
//  Brief    : Prescaler for the up/down counter. Counts enabled cycles and
//             raises tick on the last cycle of each PRESCALE-cycle period.
//             A partial count is kept while en is low; clr restarts the
//             period from zero.
//  Revision : 1.0  initial release
// ============================================================================
module updown_counter_param_prescaler_tick
    import updown_counter_param_pkg::*;
#(
    parameter int PRESCALE = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int                 c_cnt_w = prescale_cnt_width(PRESCALE);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(PRESCALE - 1);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               w_at_last;

    assign w_at_last = (r_cnt == c_last);

    // Phase counter: cleared by reset or clr, advances on enabled cycles and
    // rolls back to zero at the end of each period.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_at_last ? '0 : (r_cnt + c_one);
        end
    end

    assign tick = en & ~clr & w_at_last;

endmodule : updown_counter_param_prescaler_tick
`default_nettype wire

// File: rtl/updown_counter_param.sv
`default_nettype none
// ============================================================================
//  Module   : updown_counter_param
//  Brief    : Parametrised up/down modulo counter with wrap/saturate mode,
//             clamped parallel load, enable and an optional prescaler.
//             tc flags the step that crosses (or would cross) the count
//             boundary so stages can be cascaded tc -> en; zero flags q == 0.
//  Revision : 1.0  initial release
// ============================================================================
module updown_counter_param
    import updown_counter_param_pkg::*;
#(
    parameter int     WIDTH    = 4,
    parameter longint MODULUS  = 16,
    parameter int     SATURATE = 0,
    parameter int     PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             zero
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter legality
    // ------------------------------------------------------------------
    if ((WIDTH < MIN_WIDTH) || (WIDTH > MAX_WIDTH)) begin : g_bad_width
        $error("updown_counter_param: WIDTH=%0d outside 1..32", WIDTH);
    end

    if ((MODULUS < 2) || (MODULUS > (longint'(1) << WIDTH))) begin : g_bad_modulus
        $error("updown_counter_param: MODULUS=%0d outside 2..2**WIDTH", MODULUS);
    end

    if ((PRESCALE < MIN_PRESCALE) || (PRESCALE > MAX_PRESCALE)) begin : g_bad_prescale
        $error("updown_counter_param: PRESCALE=%0d outside 1..65535", PRESCALE);
    end

    if ((SATURATE != MODE_WRAP) && (SATURATE != MODE_SAT)) begin : g_bad_mode
        $error("updown_counter_param: SATURATE=%0d must be 0 or 1", SATURATE);
    end

    // Highest reachable count; all ones when MODULUS == 2**WIDTH, in which
    // case the load clamp below can never trigger.
    localparam logic [WIDTH-1:0] c_max_val = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] c_one     = WIDTH'(1);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_load_clamped;
    logic             w_count_en;
    logic             w_tick;
    logic             w_step;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_at_boundary;

    // A load cycle never advances the count or the prescaler.
    assign w_count_en = en & ~load;

    // ------------------------------------------------------------------
    // Step generation: direct when PRESCALE == 1, otherwise via prescaler
    // ------------------------------------------------------------------
    if (PRESCALE > 1) begin : g_prescaler
        updown_counter_param_prescaler_tick #(
            .PRESCALE (PRESCALE)
        ) u_prescaler (
            .clk  (clk),
            .rst  (rst),
            .en   (w_count_en),
            .clr  (load),
            .tick (w_tick)
        );
    end else begin : g_no_prescaler
        assign w_tick = w_count_en;
    end

    assign w_step = w_count_en & w_tick;

    // ------------------------------------------------------------------
    // Boundary detection: the boundary depends on the current direction
    // ------------------------------------------------------------------
    assign w_at_max      = (r_q == c_max_val);
    assign w_at_zero     = (r_q == '0);
    assign w_at_boundary = (down == DIR_UP) ? w_at_max : w_at_zero;

    // Loads above the modulus are pinned to the top count.
    assign w_load_clamped = (load_val > c_max_val) ? c_max_val : load_val;

    // Next-count selection: load beats step; at the boundary either wrap to
    // the opposite end or hold, depending on the mode.
    always_comb begin
        w_q_next = r_q;
        if (load) begin
            w_q_next = w_load_clamped;
        end else if (w_step) begin
            if (w_at_boundary) begin
                if (SATURATE == MODE_WRAP) begin
                    w_q_next = (down == DIR_DOWN) ? c_max_val : '0;
                end
            end else begin
                w_q_next = (down == DIR_DOWN) ? (r_q - c_one) : (r_q + c_one);
            end
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_q <= '0;
        end else begin
            r_q <= w_q_next;
        end
    end

    assign q    = r_q;
    assign tc   = w_step & w_at_boundary;
    assign zero = w_at_zero;

endmodule : updown_counter_param
`default_nettype wire

// File: tb/tb_updown_counter_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_updown_counter_param
//  Brief    : Self-checking bench for updown_counter_param. Instances:
//             0 = M10 wrap, 1 = M10 saturate, 2 = M10 prescale 3,
//             3 = M16 wrap (natural overflow), plus a two-stage decade
//             cascade. Directed table, hand sequences and random stimulus
//             against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_updown_counter_param;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] rst_v, en_v, down_v, load_v, tc_v, zero_v;
    logic [3:0] lv_v [4];
    logic [3:0] q_v  [4];

    logic       c_rst, c_en;
    logic [3:0] lo_q, hi_q;
    logic       lo_tc, hi_tc, lo_zero, hi_zero;

    int checks   = 0;
    int failures = 0;

    updown_counter_param #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .PRESCALE(1)) u_wrap (
        .clk(clk), .rst(rst_v[0]), .en(en_v[0]), .down(down_v[0]), .load(load_v[0]),
        .load_val(lv_v[0]), .q(q_v[0]), .tc(tc_v[0]), .zero(zero_v[0]));
    updown_counter_param #(.WIDTH(4), .MODULUS(10), .SATURATE(1), .PRESCALE(1)) u_sat (
        .clk(clk), .rst(rst_v[1]), .en(en_v[1]), .down(down_v[1]), .load(load_v[1]),
        .load_val(lv_v[1]), .q(q_v[1]), .tc(tc_v[1]), .zero(zero_v[1]));
    updown_counter_param #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .PRESCALE(3)) u_pre (
        .clk(clk), .rst(rst_v[2]), .en(en_v[2]), .down(down_v[2]), .load(load_v[2]),
        .load_val(lv_v[2]), .q(q_v[2]), .tc(tc_v[2]), .zero(zero_v[2]));
    updown_counter_param #(.WIDTH(4), .MODULUS(16), .SATURATE(0), .PRESCALE(1)) u_full (
        .clk(clk), .rst(rst_v[3]), .en(en_v[3]), .down(down_v[3]), .load(load_v[3]),
        .load_val(lv_v[3]), .q(q_v[3]), .tc(tc_v[3]), .zero(zero_v[3]));

    updown_counter_param #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .PRESCALE(1)) u_lo (
        .clk(clk), .rst(c_rst), .en(c_en), .down(1'b0), .load(1'b0),
        .load_val(4'd0), .q(lo_q), .tc(lo_tc), .zero(lo_zero));
    updown_counter_param #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .PRESCALE(1)) u_hi (
        .clk(clk), .rst(c_rst), .en(lo_tc), .down(1'b0), .load(1'b0),
        .load_val(4'd0), .q(hi_q), .tc(hi_tc), .zero(hi_zero));

    typedef struct {
        logic       r, e, d, l;
        logic [3:0] lv;
        logic       exp_tc;
        int         exp_q;
    } vec_t;

    vec_t vecs[$];

    // Model parameters per instance index
    int m_mod [4] = '{10, 10, 10, 16};
    int m_sat [4] = '{0, 1, 0, 0};
    int m_pre [4] = '{1, 1, 3, 1};
    int m_q   [4];
    int m_pc  [4];

    function automatic void add(input logic r, e, d, l, input int lv, input logic etc, input int eq);
        vec_t v;
        v.r = r; v.e = e; v.d = d; v.l = l; v.lv = 4'(lv); v.exp_tc = etc; v.exp_q = eq;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural reference: one clock of the counter in plain arithmetic.
    function automatic void ref_cycle(input int m, sat, pre, input logic r, e, d, l,
                                      input int lv, inout int q, inout int pc, output logic tc);
        logic adv, at_edge;
        adv     = e && !l && (pc == pre - 1);
        at_edge = d ? (q == 0) : (q == m - 1);
        tc      = adv && at_edge;
        if (!r) begin
            q = 0; pc = 0;
        end else if (l) begin
            q = (lv < m) ? lv : m - 1; pc = 0;
        end else if (e) begin
            pc = (pc + 1) % pre;
            if (adv && !(sat != 0 && at_edge))
                q = (q + (d ? m - 1 : 1)) % m;
        end
    endfunction

    // One directed cycle on instance w: tc checked before the edge, q/zero after.
    task automatic cyc(input int w, input logic r, e, d, l, input logic [3:0] lv,
                       input logic etc, input int eq, input string nm);
        @(negedge clk);
        rst_v[w] = r; en_v[w] = e; down_v[w] = d; load_v[w] = l; lv_v[w] = lv;
        #1;
        chk({nm, "_tc"}, int'(tc_v[w]), int'(etc));
        @(posedge clk);
        #1;
        chk({nm, "_q"}, int'(q_v[w]), eq);
        chk({nm, "_zero"}, int'(zero_v[w]), int'(eq == 0));
    endtask

    initial begin
        logic etc;

        // Directed table for the M10 wrap instance
        add(1, 0, 0, 1, 7, 0, 7);                       // reach q=7
        add(0, 0, 0, 0, 0, 0, 0);                       // reset held two cycles
        add(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i <= 10; i++) begin             // down 0,9,8..0,9
            int cur;
            cur = (10 - i) % 10;
            add(1, 1, 1, 0, 0, cur == 0, (cur == 0) ? 9 : cur - 1);
        end
        add(1, 0, 0, 1, 0, 0, 0);                       // load 0
        for (int k = 0; k < 10; k++) add(1, 1, 0, 0, 0, k == 9, (k + 1) % 10);
        add(1, 0, 0, 1, 9, 0, 9);                       // load 9, then disabled
        for (int k = 0; k < 3; k++) add(1, 0, 0, 0, 0, 0, 9);
        add(1, 1, 0, 1, 13, 0, 9);                      // clamp, no step
        add(1, 1, 0, 1, 4, 0, 4);
        add(0, 0, 0, 1, 5, 0, 0);                       // reset beats load
        add(1, 1, 1, 1, 15, 0, 9);                      // load at q=0 down: no tc
        add(1, 0, 0, 0, 0, 0, 9);                       // hold, counting up
        add(1, 1, 1, 0, 0, 0, 8);                       // flip at boundary
        add(1, 1, 0, 0, 0, 0, 9);
        add(1, 1, 0, 0, 0, 1, 0);                       // up wrap

        // Reset everything and check the reset state
        @(negedge clk);
        rst_v = '0; en_v = '0; down_v = '0; load_v = '0;
        for (int i = 0; i < 4; i++) lv_v[i] = '0;
        c_rst = 1'b0; c_en = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            chk("reset_q", int'(q_v[i]), 0);
            chk("reset_zero", int'(zero_v[i]), 1);
            chk("reset_tc", int'(tc_v[i]), 0);
        end
        @(negedge clk);
        rst_v = '1;

        foreach (vecs[i])
            cyc(0, vecs[i].r, vecs[i].e, vecs[i].d, vecs[i].l, vecs[i].lv,
                vecs[i].exp_tc, vecs[i].exp_q, $sformatf("tbl%0d", i));

        // Saturate mode
        cyc(1, 1, 0, 1, 1, 2, 0, 2, "sat_ld");
        cyc(1, 1, 1, 1, 0, 0, 0, 1, "sat_d1");
        cyc(1, 1, 1, 1, 0, 0, 0, 0, "sat_d0");
        cyc(1, 1, 1, 1, 0, 0, 1, 0, "sat_hold0a");
        cyc(1, 1, 1, 1, 0, 0, 1, 0, "sat_hold0b");
        cyc(1, 1, 1, 0, 0, 0, 0, 1, "sat_up");
        cyc(1, 1, 0, 0, 1, 9, 0, 9, "sat_ld9");
        cyc(1, 1, 1, 0, 0, 0, 1, 9, "sat_hold9");

        // Prescale 3
        for (int k = 0; k < 6; k++)
            cyc(2, 1, 1, 0, 0, 0, 0, (k + 1) / 3, "pre_run");
        cyc(2, 1, 1, 0, 0, 0, 0, 2, "pre_part");
        cyc(2, 1, 0, 0, 0, 0, 0, 2, "pre_off1");
        cyc(2, 1, 0, 0, 0, 0, 0, 2, "pre_off2");
        cyc(2, 1, 1, 0, 0, 0, 0, 2, "pre_resume");
        cyc(2, 1, 1, 0, 0, 0, 0, 3, "pre_step");
        cyc(2, 1, 1, 0, 0, 0, 0, 3, "pre_part2");
        cyc(2, 1, 1, 0, 1, 5, 0, 5, "pre_load");
        cyc(2, 1, 1, 0, 0, 0, 0, 5, "pre_rst1");
        cyc(2, 1, 1, 0, 0, 0, 0, 5, "pre_rst2");
        cyc(2, 1, 1, 0, 0, 0, 0, 6, "pre_rst3");
        cyc(2, 1, 0, 0, 1, 9, 0, 9, "pre_ld9");
        cyc(2, 1, 1, 0, 0, 0, 0, 9, "pre_w1");
        cyc(2, 1, 1, 0, 0, 0, 0, 9, "pre_w2");
        cyc(2, 1, 1, 0, 0, 0, 1, 0, "pre_wrap");

        // Two-stage decade cascade
        @(negedge clk);
        c_rst = 1'b1; c_en = 1'b1;
        for (int k = 0; k < 100; k++) begin
            #1;
            chk("casc_lo_tc", int'(lo_tc), int'(k % 10 == 9));
            chk("casc_hi_tc", int'(hi_tc), int'(k == 99));
            @(posedge clk); #1;
            chk("casc_count", int'(hi_q) * 10 + int'(lo_q), (k + 1) % 100);
            @(negedge clk);
        end
        c_en = 1'b0;

        // Random stimulus against the reference model
        rst_v = '0; en_v = '0; load_v = '0;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin m_q[i] = 0; m_pc[i] = 0; end
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                rst_v[i]  = ($urandom_range(0, 29) != 0);
                en_v[i]   = ($urandom_range(0, 3) != 0);
                down_v[i] = 1'($urandom_range(0, 1));
                load_v[i] = ($urandom_range(0, 9) == 0);
                lv_v[i]   = 4'($urandom_range(0, 15));
            end
            #1;
            for (int i = 0; i < 4; i++) begin
                ref_cycle(m_mod[i], m_sat[i], m_pre[i], rst_v[i], en_v[i], down_v[i],
                          load_v[i], int'(lv_v[i]), m_q[i], m_pc[i], etc);
                chk($sformatf("rnd%0d_tc", i), int'(tc_v[i]), int'(etc));
            end
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("rnd%0d_q", i), int'(q_v[i]), m_q[i]);
                chk($sformatf("rnd%0d_zero", i), int'(zero_v[i]), int'(m_q[i] == 0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_updown_counter_param
`default_nettype wire
